led_ctrl: RTL
=============

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameters SHALL be:
  - N_CH, default 2, number of LED channels (1..16).
  - CLK_HZ, default 50_000_000, clk frequency.
  - TICK_HZ, default 1000, timebase tick rate.
  - PWM_W, default 8, brightness resolution in bits.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, sole clock.
  - rst, in, 1, asynchronous active-high reset.
  - cfg_we, in, 1, one-cycle config write strobe.
  - cfg_ch, in, max(1,$clog2(N_CH)), target channel.
  - cfg_mode, in, 2, 0=OFF, 1=ON, 2=BLINK, 3=BREATHE.
  - cfg_period, in, 16, blink half-period or breathe step, in ticks.
  - cfg_duty, in, PWM_W, brightness.
  - cfg_ack, out, 1, write accepted.
  - cfg_err, out, 1, write rejected.
  - tick, out, 1, timebase pulse.
  - led, out, N_CH, LED drive, 1 = lit.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and wrap; tick SHALL be high for exactly the one cycle in which the prescaler wraps.
REQ-005 A shared free-running PWM_W-bit counter pwm_cnt SHALL increment every clk and wrap from all-ones to 0.
REQ-006 pwm_on(d) SHALL equal (pwm_cnt < d) OR (d == all-ones), so duty 0 is dark and all-ones is fully lit.
REQ-007 OFF: led[i] SHALL be 0.
REQ-008 ON: led[i] SHALL be pwm_on(duty[i]).
REQ-009 BLINK behaviour:
  - The per-channel 16-bit tick counter SHALL advance on tick.
  - On reaching eff_period-1, the counter SHALL clear and phase[i] SHALL toggle.
  - led[i] SHALL be phase[i] AND pwm_on(duty[i]).
REQ-010 eff_period SHALL be cfg_period, or 1 when cfg_period is 0.
REQ-011 led SHALL be registered, with exactly one cycle of latency from the pwm_cnt/phase state to the pin.
REQ-012 Write acceptance:
  - Condition: cfg_we=1 and cfg_ch<N_CH.
  - On the next edge, mode/period/duty of that channel SHALL load, and its tick counter, phase and breathe level SHALL clear.
  - cfg_ack SHALL pulse one cycle after the write.
REQ-013 A write with cfg_ch>=N_CH SHALL change no state, and cfg_err SHALL pulse one cycle after the write.
REQ-014 When a write and a tick hit the same channel in the same cycle, the write SHALL win, and the counter SHALL be 0 afterwards.
REQ-015 Writes to other channels SHALL NOT disturb a channel's counter, phase or output.
REQ-016 Back-to-back writes on consecutive cycles SHALL all be accepted, one ack per write.

Reset
REQ-017 While rst=1, all of the following SHALL be 0:
  - every channel's mode (OFF), period, duty, counter, phase and breathe level
  - pwm_cnt and the prescaler
  - led, tick, cfg_ack and cfg_err
REQ-018 Reset assertion mid-blink SHALL force led to 0 asynchronously; after release, counting SHALL restart from 0.

Configuration
REQ-019 With macro LED_BREATHE_EN defined, BREATHE mode SHALL operate as follows:
  - level[i] SHALL step by 1 every eff_period ticks.
  - It SHALL ramp 0 up to duty[i], then back down to 0, and repeat.
  - Direction SHALL reverse at the endpoints without dwelling twice.
  - led[i] SHALL be pwm_on(level[i]).
REQ-020 Without LED_BREATHE_EN, the level/direction logic SHALL be absent, and mode 3 SHALL behave exactly as ON.

Structure
REQ-021 Package led_pkg SHALL hold:
  - the mode enum (LED_OFF, LED_ON, LED_BLINK, LED_BREATHE)
  - the PERIOD_W=16 constant
  - the eff_period helper function
REQ-022 Per-channel state and output logic SHALL reside in sub-module led_channel, instantiated N_CH times by generate.
REQ-023 The prescaler, pwm_cnt and write decode SHALL reside in led_ctrl.

Verification (CLK_HZ=1000, TICK_HZ=100, so tick every 10 clk; PWM_W=8; N_CH=2)
REQ-024 Reset then idle 100 clk: led=0; tick seen exactly 10 times, spaced 10 clk.
REQ-025 ch0 ON, duty=64: led[0] high 64 of every 256 clk; duty=255: led[0] constantly 1; duty=0: constantly 0.
REQ-026 ch1 BLINK, period=3, duty=255: led[1] toggles every 30 clk; period=0 toggles every 10 clk.
REQ-027 Write with cfg_ch=2: cfg_err pulses once, no cfg_ack, both channels unchanged; a write coincident with tick clears the counter.
REQ-028 With LED_BREATHE_EN, ch0 BREATHE, period=1, duty=4: level sequence 0,1,2,3,4,3,2,1,0,1 at successive ticks; without the macro, led[0] equals ON behaviour.
REQ-029 Assert rst mid-blink while led[1]=1: led drops to 0 without waiting for a clk edge; the first toggle after release occurs eff_period ticks later.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED controller: channel modes and period handling.
// The BREATHE mode is only fully built when LED_BREATHE_EN is defined.
package led_pkg;

    localparam int PERIOD_W = 16;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_e;

    // A zero period would never wrap the tick counter, so it is treated as one tick.
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] period);
        if (period == 16'd0) begin
            return 16'd1;
        end else begin
            return period;
        end
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: configuration registers, tick counter, blink phase and registered drive.
// Macro LED_BREATHE_EN adds the breathe level ramp; without it mode 3 acts as ON.
module led_channel
    import led_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [PWM_W-1:0]    pwm_cnt,
    input  logic                wr_en,
    input  logic [1:0]          wr_mode,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [PWM_W-1:0]    wr_duty,
    output logic                led
);

    localparam logic [PWM_W-1:0] ONE_L = PWM_W'(1'b1);

    led_mode_e             mode_r;
    logic [PERIOD_W-1:0]   period_r;
    logic [PERIOD_W-1:0]   cnt_r;
    logic [PWM_W-1:0]      duty_r;
    logic                  phase_r;
    logic                  led_r;
    logic                  run_s;
    logic                  wrap_s;
    logic                  led_nxt_s;

    function automatic logic pwm_on(input logic [PWM_W-1:0] cnt, input logic [PWM_W-1:0] d);
        return (cnt < d) || (d == {PWM_W{1'b1}});
    endfunction

    // Tick counter runs only in the timed modes and wraps at eff_period-1.
    always_comb begin
        run_s  = tick && ((mode_r == LED_BLINK) || (mode_r == LED_BREATHE));
        wrap_s = (cnt_r == (eff_period(period_r) - 16'd1));
    end

    // Configuration load, tick counting and blink phase; a write beats a same-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= LED_OFF;
            period_r <= 16'd0;
            duty_r   <= '0;
            cnt_r    <= 16'd0;
            phase_r  <= 1'b0;
        end else if (wr_en) begin
            mode_r   <= led_mode_e'(wr_mode);
            period_r <= wr_period;
            duty_r   <= wr_duty;
            cnt_r    <= 16'd0;
            phase_r  <= 1'b0;
        end else if (run_s) begin
            if (wrap_s) begin
                cnt_r   <= 16'd0;
                phase_r <= ~phase_r;
            end else begin
                cnt_r   <= cnt_r + 16'd1;
            end
        end
    end

`ifdef LED_BREATHE_EN
    logic [PWM_W-1:0] level_r;
    logic             dir_down_r;

    // Triangle ramp 0..duty..0; the endpoint turns around without repeating a level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r    <= '0;
            dir_down_r <= 1'b0;
        end else if (wr_en) begin
            level_r    <= '0;
            dir_down_r <= 1'b0;
        end else if (run_s && wrap_s && (mode_r == LED_BREATHE)) begin
            if (!dir_down_r) begin
                if (level_r >= duty_r) begin
                    dir_down_r <= 1'b1;
                    if (level_r != '0) begin
                        level_r <= level_r - ONE_L;
                    end
                end else begin
                    level_r <= level_r + ONE_L;
                end
            end else begin
                if (level_r == '0) begin
                    dir_down_r <= 1'b0;
                    if (duty_r != '0) begin
                        level_r <= ONE_L;
                    end
                end else begin
                    level_r <= level_r - ONE_L;
                end
            end
        end
    end
`endif

    // Next LED value from the current mode state.
    always_comb begin
        led_nxt_s = 1'b0;
        case (mode_r)
            LED_OFF:     led_nxt_s = 1'b0;
            LED_ON:      led_nxt_s = pwm_on(pwm_cnt, duty_r);
            LED_BLINK:   led_nxt_s = phase_r && pwm_on(pwm_cnt, duty_r);
`ifdef LED_BREATHE_EN
            LED_BREATHE: led_nxt_s = pwm_on(pwm_cnt, level_r);
`else
            LED_BREATHE: led_nxt_s = pwm_on(pwm_cnt, duty_r);
`endif
            default:     led_nxt_s = 1'b0;
        endcase
    end

    // Registered pin drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 1'b0;
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign led = led_r;

endmodule

// File: rtl/led_ctrl.sv
// LED controller top: tick prescaler, shared PWM counter, config write decode and channels.
// Define LED_BREATHE_EN to enable the BREATHE ramp in every channel.
module led_ctrl
    import led_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int PWM_W   = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                 cfg_mode,
    input  logic [PERIOD_W-1:0]                        cfg_period,
    input  logic [PWM_W-1:0]                           cfg_duty,
    output logic                                       cfg_ack,
    output logic                                       cfg_err,
    output logic                                       tick,
    output logic [N_CH-1:0]                            led
);

    localparam int               CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int               DIV     = CLK_HZ / TICK_HZ;
    localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [CH_W:0]    N_CH_L  = (CH_W + 1)'(N_CH);

    logic [PRE_W-1:0] pre_r;
    logic             tick_r;
    logic [PWM_W-1:0] pwm_cnt_r;
    logic             ack_r;
    logic             err_r;
    logic             in_range_s;
    logic             wr_ok_s;

    // Prescaler wraps at DIV-1; tick marks the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            pre_r  <= (pre_r == PRE_MAX) ? '0 : pre_r + PRE_W'(1'b1);
            tick_r <= (pre_r == PRE_MAX);
        end
    end

    // Free-running PWM reference shared by all channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_W'(1'b1);
        end
    end

    // Out-of-range channel numbers are rejected without touching any channel.
    always_comb begin
        in_range_s = ({1'b0, cfg_ch} < N_CH_L);
        wr_ok_s    = cfg_we && in_range_s;
    end

    // One-cycle accept/reject pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ack_r <= wr_ok_s;
            err_r <= cfg_we && !in_range_s;
        end
    end

    assign cfg_ack = ack_r;
    assign cfg_err = err_r;
    assign tick    = tick_r;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_en_s;
        assign wr_en_s = wr_ok_s && (cfg_ch == CH_W'(i));

        led_channel #(
            .PWM_W(PWM_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_r),
            .pwm_cnt   (pwm_cnt_r),
            .wr_en     (wr_en_s),
            .wr_mode   (cfg_mode),
            .wr_period (cfg_period),
            .wr_duty   (cfg_duty),
            .led       (led[i])
        );
    end

endmodule
